fb_mem_arbiter: RTL and testbench
=================================

Name: fb_mem_arbiter

Overview:
- Sequences the shared framebuffer memory (PSRAM controller command port) between two requesters.
- Requester 1 is the LCD refill path, which reads fixed-length pixel bursts to keep the LCD pixel FIFO from running dry.
- Requester 2 is a host port for single-word reads and writes.
- The LCD path has priority, with bounded starvation of the host. The block sits between the LCD pixel-fetch logic / host bus and the PSRAM controller.

Parameters:
- ADDR_W, 22, word address width on all address ports
- DATA_W, 16, data word width (RGB565)
- BURST_LEN, 16, beats per LCD read burst (2..255)
- STARVE_MAX, 4, consecutive LCD grants allowed while host_req is pending before the host is forced in (1..15)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- lcd_req  in  1  LCD path requests one burst; held until lcd_grant
- lcd_addr  in  ADDR_W  burst start word address; stable while lcd_req=1
- lcd_grant  out  1  one-cycle pulse: burst command accepted by memory
- lcd_rvalid  out  1  one pixel word valid this cycle
- lcd_rdata  out  DATA_W  pixel word
- host_req  in  1  host transaction request; held until host_ack
- host_we  in  1  1=write, 0=read
- host_addr  in  ADDR_W  host word address
- host_wdata  in  DATA_W  host write data
- host_ack  out  1  one-cycle pulse: transaction complete
- host_rdata  out  DATA_W  read data; valid when host_ack=1 after a read, held afterwards
- mem_req  out  1  command valid
- mem_we  out  1  command is write
- mem_addr  out  ADDR_W  command start address
- mem_wdata  out  DATA_W  write data
- mem_len  out  8  beats in command (BURST_LEN or 1)
- mem_ack  in  1  command accepted this cycle (qualified by mem_req)
- mem_rvalid  in  1  read beat valid
- mem_rdata  in  DATA_W  read beat data
- mem_done  in  1  transaction retired (last read beat or write committed)
- err  out  1  sticky: LCD burst ended with beat count != BURST_LEN

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE. All outputs are 0, starve_cnt=0, beat_cnt=0. Reset mid-transaction abandons it; the memory controller shares the reset.
- FSM states: IDLE, LCD_CMD, LCD_DATA, HOST_CMD, HOST_WAIT.
- IDLE arbitration, evaluated every cycle:
  - Take the LCD if lcd_req && (!host_req || starve_cnt < STARVE_MAX).
  - Otherwise take the host if host_req.
  - Otherwise stay in IDLE.
  - The winner's address, data and we are latched into mem_* registers. mem_req=1 from the next cycle.
- LCD_CMD: mem_req=1, mem_we=0, mem_len=BURST_LEN. On mem_ack: lcd_grant pulses that same cycle, mem_req drops the next cycle, and the FSM moves to LCD_DATA.
- LCD_DATA:
  - Each mem_rvalid registers mem_rdata to lcd_rdata and raises lcd_rvalid one cycle later (1-cycle latency). beat_cnt increments on each beat.
  - On mem_done: return to IDLE. If the final beat_cnt (including a beat coincident with mem_done) != BURST_LEN, set err.
- HOST_CMD: mem_req=1, mem_len=1, mem_we=host_we. On mem_ack, go to HOST_WAIT.
- HOST_WAIT:
  - For a read, capture mem_rdata on mem_rvalid into host_rdata.
  - On mem_done, pulse host_ack the next cycle and return to IDLE. The next arbitration happens in the cycle host_ack is high, with host_req still visible but already served.
  - The host must drop host_req or present a new request by the cycle after host_ack. The block ignores host_req during the host_ack cycle.
- starve_cnt (4 bits):
  - +1 on each lcd_grant while host_req=1, saturating.
  - Cleared when a host command is accepted or when host_req=0.
- mem_* command fields are stable from mem_req rise until mem_ack. mem_req never deasserts without mem_ack.
- lcd_rvalid is never 1 outside beats of a granted LCD burst. mem_rvalid seen in IDLE or the host states is not forwarded to the LCD.
- Simultaneous mem_ack and mem_done in the same cycle: both are honoured; the FSM goes to IDLE directly.
- Simultaneous lcd_req and host_req with starve_cnt=STARVE_MAX: the host wins.
- err clears only on reset.

Test Plan:
- LCD only: lcd_req=1, lcd_addr=0x000320, BURST_LEN=16, memory acks after 2 cycles and returns 16 beats 0x0000..0x000F then mem_done -> one mem_req with addr 0x000320 len 16; lcd_grant pulses once; 16 lcd_rvalid with data 0x0000..0x000F, each 1 cycle after its beat; err=0.
- Host write then read: write 0xF800 to 0x000005, then read 0x000005 with the model returning 0xF800 -> mem_we=1/len=1 then mem_we=0/len=1; two host_ack pulses; host_rdata=0xF800 at the second ack.
- Starvation bound: lcd_req and host_req held high continuously, STARVE_MAX=4 -> grant order LCD, LCD, LCD, LCD, HOST, LCD, …; starve_cnt returns to 0 after the host command is accepted.
- Short burst: memory returns only 15 beats, then mem_done -> FSM back in IDLE; err=1 and stays 1 through later good bursts.
- Reset mid-burst: reset_n low after 7 of 16 beats, then released -> all outputs 0 immediately; the next lcd_req produces a fresh mem_req; no stale lcd_rvalid.
- mem_ack coincident with mem_done on a host write -> single host_ack; FSM in IDLE the next cycle; no second mem_req.

Source files
------------

// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter: shares the PSRAM command port between LCD burst refill and a single-word host port.
// The LCD has priority, but once the host has waited STARVE_MAX LCD grants the host is taken next.
module fb_mem_arbiter #(
   parameter int ADDR_W     = 22,
   parameter int DATA_W     = 16,
   parameter int BURST_LEN  = 16,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              lcd_req,
   input  logic [ADDR_W-1:0] lcd_addr,
   output logic              lcd_grant,
   output logic              lcd_rvalid,
   output logic [DATA_W-1:0] lcd_rdata,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_ack,
   output logic [DATA_W-1:0] host_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [7:0]        mem_len,
   input  logic              mem_ack,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_done,
   output logic              err
);
   typedef enum logic [2:0] {IDLE, LCD_CMD, LCD_DATA, HOST_CMD, HOST_WAIT} state_t;
   state_t     state;
   logic [3:0] starve_cnt;
   logic [7:0] beat_cnt;
   logic [7:0] beats;
   logic       host_live;
   logic       pick_lcd;
   logic       pick_host;
   // a host_req still high in the host_ack cycle belongs to the transaction just served
   assign host_live = host_req && !host_ack;
   assign pick_lcd  = lcd_req && (!host_live || starve_cnt < 4'(STARVE_MAX));
   assign pick_host = host_live && !pick_lcd;
   assign lcd_grant = (state == LCD_CMD) && mem_ack;
   assign beats     = beat_cnt + {7'd0, mem_rvalid};
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         starve_cnt <= '0;
         beat_cnt   <= '0;
         lcd_rvalid <= 1'b0;
         lcd_rdata  <= '0;
         host_ack   <= 1'b0;
         host_rdata <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_len    <= '0;
         err        <= 1'b0;
      end else begin
         lcd_rvalid <= (state == LCD_DATA) && mem_rvalid;
         if ((state == LCD_DATA) && mem_rvalid) lcd_rdata <= mem_rdata;
         if ((state == HOST_WAIT || (state == HOST_CMD && mem_ack)) && !mem_we && mem_rvalid)
            host_rdata <= mem_rdata;
         host_ack <= 1'b0;
         if (!host_req || (state == HOST_CMD && mem_ack)) starve_cnt <= '0;
         else if (lcd_grant && starve_cnt != 4'hf) starve_cnt <= starve_cnt + 4'd1;
         case (state)
            IDLE: if (pick_lcd || pick_host) begin
               mem_req   <= 1'b1;
               mem_we    <= pick_host && host_we;
               mem_addr  <= pick_lcd ? lcd_addr : host_addr;
               mem_wdata <= pick_lcd ? '0 : host_wdata;
               mem_len   <= pick_lcd ? 8'(BURST_LEN) : 8'd1;
               state     <= pick_lcd ? LCD_CMD : HOST_CMD;
            end
            LCD_CMD: if (mem_ack) begin
               mem_req  <= 1'b0;
               beat_cnt <= '0;
               state    <= mem_done ? IDLE : LCD_DATA;
               if (mem_done) err <= 1'b1;
            end
            LCD_DATA: begin
               beat_cnt <= mem_done ? '0 : beats;
               if (mem_done) begin
                  err   <= err | (beats != 8'(BURST_LEN));
                  state <= IDLE;
               end
            end
            HOST_CMD: if (mem_ack) begin
               mem_req  <= 1'b0;
               host_ack <= mem_done;
               state    <= mem_done ? IDLE : HOST_WAIT;
            end
            HOST_WAIT: if (mem_done) begin
               host_ack <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fb_mem_arbiter.sv
// tb_fb_mem_arbiter: table-driven, directed and randomized checks of fb_mem_arbiter
// against a transaction-level model of arbitration, memory contents and the sticky error.
module tb_fb_mem_arbiter;
   localparam int AW = 22;
   localparam int DW = 16;
   localparam int BL = 16;
   localparam int SM = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          lcd_req = 1'b0;
   logic [AW-1:0] lcd_addr = '0;
   logic          lcd_grant, lcd_rvalid;
   logic [DW-1:0] lcd_rdata;
   logic          host_req = 1'b0, host_we = 1'b0;
   logic [AW-1:0] host_addr = '0;
   logic [DW-1:0] host_wdata = '0;
   logic          host_ack;
   logic [DW-1:0] host_rdata;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [7:0]    mem_len;
   logic          mem_ack = 1'b0, mem_rvalid = 1'b0, mem_done = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   logic          err;

   fb_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .STARVE_MAX(SM)) dut (
      .clk(clk), .reset_n(reset_n),
      .lcd_req(lcd_req), .lcd_addr(lcd_addr), .lcd_grant(lcd_grant),
      .lcd_rvalid(lcd_rvalid), .lcd_rdata(lcd_rdata),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_len(mem_len), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .mem_done(mem_done), .err(err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit err_exp = 1'b0;
   bit hold_reqs = 1'b0;
   int waited = 0;
   logic [DW-1:0] mem_m [logic [AW-1:0]];

   typedef struct {
      bit            lcd;
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            ack_dly;
      int            beats;
      bit            coinc;
      logic [DW-1:0] exp_rdata;
      bit            exp_err;
   } vec_t;
   vec_t tab[7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // backing store: written words, else a linear pattern that makes 0x320.. read 0,1,2..
   function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
      return mem_m.exists(a) ? mem_m[a] : a[15:0] - 16'h0320;
   endfunction

   // Acts as the memory for one command; returns in the first IDLE cycle afterwards.
   task automatic serve(input bit exp_lcd, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int ack_dly, input int beats,
                        input bit coinc);
      int n = 0;
      logic [AW-1:0] a;
      while (!mem_req && n < 30) begin tick(); n++; end
      check("mem_req_rise", mem_req, 1);
      check("mem_len", mem_len, exp_lcd ? 32'(BL) : 32'd1);
      check("mem_we", mem_we, exp_lcd ? 0 : we);
      check("mem_addr", mem_addr, addr);
      if (!exp_lcd && we) check("mem_wdata", mem_wdata, wdata);
      repeat (ack_dly) begin
         tick();
         check("mem_req_hold", mem_req, 1);
         check("mem_addr_hold", mem_addr, addr);
      end
      mem_ack = 1'b1;
      mem_done = !exp_lcd && we && coinc;
      #1;
      check("lcd_grant", lcd_grant, exp_lcd);
      tick();
      mem_ack = 1'b0;
      mem_done = 1'b0;
      check("mem_req_drop", mem_req, 0);
      if (exp_lcd) begin
         if (!hold_reqs) lcd_req = 1'b0;
         check("lcd_rvalid_pre", lcd_rvalid, 0);
         for (int i = 0; i < beats; i++) begin
            a = addr + AW'(i);
            mem_rvalid = 1'b1;
            mem_rdata = rd(a);
            mem_done = (i == beats - 1);
            tick();
            check("lcd_rvalid", lcd_rvalid, 1);
            check("lcd_rdata", lcd_rdata, rd(a));
         end
         mem_rvalid = 1'b0;
         mem_done = 1'b0;
         err_exp |= (beats != BL);
         check("err", err, err_exp);
      end else begin
         if (we) begin
            if (!coinc) begin
               mem_done = 1'b1;
               tick();
               mem_done = 1'b0;
            end
            mem_m[addr] = wdata;
         end else begin
            mem_rvalid = 1'b1;
            mem_rdata = rd(addr);
            mem_done = 1'b1;
            tick();
            mem_rvalid = 1'b0;
            mem_done = 1'b0;
            check("lcd_rvalid_host", lcd_rvalid, 0);
         end
         check("host_ack", host_ack, 1);
         if (!we) check("host_rdata", host_rdata, rd(addr));
         if (!hold_reqs) host_req = 1'b0;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit pred_lcd;
      int beats;
      tab[0] = '{1, 0, 22'h000320, 16'h0000, 2, 16, 0, 16'h0000, 0};
      tab[1] = '{0, 1, 22'h000005, 16'hF800, 1, 0, 0, 16'h0000, 0};
      tab[2] = '{0, 0, 22'h000005, 16'h0000, 0, 0, 0, 16'hF800, 0};
      tab[3] = '{0, 1, 22'h000009, 16'h1234, 0, 0, 1, 16'h0000, 0};
      tab[4] = '{1, 0, 22'h001000, 16'h0000, 1, 15, 0, 16'h0000, 1};
      tab[5] = '{1, 0, 22'h002000, 16'h0000, 0, 16, 0, 16'h0000, 1};
      tab[6] = '{0, 0, 22'h000009, 16'h0000, 3, 0, 0, 16'h1234, 1};

      repeat (2) tick();
      check("rst_mem_req", mem_req, 0);
      check("rst_lcd_rvalid", lcd_rvalid, 0);
      check("rst_host_ack", host_ack, 0);
      check("rst_err", err, 0);
      check("rst_mem_len", mem_len, 0);
      reset_n = 1'b1;
      tick();

      for (int r = 0; r < 7; r++) begin
         if (tab[r].lcd) begin
            lcd_req = 1'b1;
            lcd_addr = tab[r].addr;
         end else begin
            host_req = 1'b1;
            host_we = tab[r].we;
            host_addr = tab[r].addr;
            host_wdata = tab[r].wdata;
         end
         serve(tab[r].lcd, tab[r].we, tab[r].addr, tab[r].wdata, tab[r].ack_dly,
               tab[r].beats, tab[r].coinc);
         if (!tab[r].lcd && !tab[r].we) check("tab_rdata", host_rdata, tab[r].exp_rdata);
         check("tab_err", err, tab[r].exp_err);
         tick();
         check("idle_mem_req", mem_req, 0);
         check("idle_lcd_rvalid", lcd_rvalid, 0);
         check("idle_host_ack", host_ack, 0);
      end

      // starvation bound: both requesters held continuously
      hold_reqs = 1'b1;
      lcd_req = 1'b1;
      lcd_addr = 22'h000400;
      host_req = 1'b1;
      host_we = 1'b0;
      host_addr = 22'h000003;
      for (int k = 0; k < 10; k++) serve(k % 5 != 4, 0, k % 5 != 4 ? lcd_addr : host_addr, '0, k % 3, BL, 0);
      hold_reqs = 1'b0;
      lcd_req = 1'b0;
      host_req = 1'b0;
      tick();
      check("starve_idle", mem_req, 0);
      tick();

      // reset in the middle of a burst
      lcd_req = 1'b1;
      lcd_addr = 22'h000040;
      for (int n = 0; n < 30 && !mem_req; n++) tick();
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      lcd_req = 1'b0;
      for (int i = 0; i < 7; i++) begin
         mem_rvalid = 1'b1;
         mem_rdata = rd(22'h000040 + AW'(i));
         tick();
      end
      check("pre_rst_rvalid", lcd_rvalid, 1);
      mem_rvalid = 1'b0;
      reset_n = 1'b0;
      #1;
      check("arst_lcd_rvalid", lcd_rvalid, 0);
      check("arst_lcd_rdata", lcd_rdata, 0);
      check("arst_host_rdata", host_rdata, 0);
      check("arst_err", err, 0);
      check("arst_mem_addr", mem_addr, 0);
      check("arst_mem_len", mem_len, 0);
      tick();
      tick();
      reset_n = 1'b1;
      err_exp = 1'b0;
      waited = 0;
      tick();
      check("post_rst_rvalid", lcd_rvalid, 0);
      check("post_rst_mem_req", mem_req, 0);
      lcd_req = 1'b1;
      serve(1, 0, 22'h000040, '0, 1, BL, 0);
      tick();
      check("post_rst_idle", mem_req, 0);

      // randomized traffic against the transaction-level model
      for (int it = 0; it < 80; it++) begin
         if (!lcd_req && $urandom_range(0, 1) == 1) begin
            lcd_req = 1'b1;
            lcd_addr = AW'($urandom);
         end
         if (!host_req && $urandom_range(0, 1) == 1) begin
            host_req = 1'b1;
            host_we = 1'($urandom);
            host_addr = AW'($urandom_range(0, 31));
            host_wdata = DW'($urandom);
         end
         if (!lcd_req && !host_req) begin
            lcd_req = 1'b1;
            lcd_addr = AW'($urandom);
         end
         if (!host_req) waited = 0;
         pred_lcd = lcd_req && (!host_req || waited < SM);
         beats = BL;
         if ($urandom_range(0, 7) == 0) beats = ($urandom_range(0, 1) == 1) ? BL + 1 : BL - 1 - int'($urandom_range(0, 2));
         serve(pred_lcd, host_we, pred_lcd ? lcd_addr : host_addr, host_wdata,
               int'($urandom_range(0, 3)), beats, 1'($urandom));
         waited = (pred_lcd && host_req) ? waited + 1 : 0;
      end
      lcd_req = 1'b0;
      host_req = 1'b0;
      repeat (40) begin
         if (mem_req) begin
            mem_ack = 1'b1;
            mem_done = 1'b1;
            tick();
            mem_ack = 1'b0;
            mem_done = 1'b0;
         end else tick();
      end
      check("final_err", err, err_exp);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
